// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline blocks.
package core_pkg;

    localparam int NUM_ARCH_REGS = 16;
    localparam int WORD_W        = 16;
    localparam int ADDR_W        = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 4'd0;

    // Operand-fetch stage occupancy.
    typedef enum logic [1:0] {
        OPF_EMPTY = 2'd0,
        OPF_WAIT  = 2'd1,
        OPF_READY = 2'd2
    } opf_state_e;

endpackage

// File: rtl/core_scoreboard.sv
// Per-register pending-write counters: incremented at issue, decremented by
// every writeback port that targets the register. Underflow clamps at zero
// and raises a sticky error flag. Register 0 is never tracked.
module core_scoreboard
    import core_pkg::*;
#(
    parameter int W_PORTS = 2,
    parameter int PEND_W  = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   inc_en_i,
    input  reg_addr_t                              inc_addr_i,
    input  logic [W_PORTS-1:0]                     dec_en_i,
    input  logic [ADDR_W*W_PORTS-1:0]              dec_addr_i,
    output logic [NUM_ARCH_REGS-1:0][PEND_W-1:0]   pend_o,
    output logic [NUM_ARCH_REGS-1:0]               sat_o,
    output logic                                   err_o
);

    // Wide enough to hold pend + 1 and the full decrement count without wrap.
    localparam int SUM_W = PEND_W + $clog2(W_PORTS + 1) + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [NUM_ARCH_REGS-1:0][PEND_W-1:0] r_pend;
    logic [NUM_ARCH_REGS-1:0][PEND_W-1:0] w_pend_nxt;
    logic [NUM_ARCH_REGS-1:0]             w_under;
    logic [SUM_W-1:0]                     w_up;
    logic [SUM_W-1:0]                     w_down;
    logic                                 r_err;

    // Net next count per register: (pend + issue) - matching writebacks, clamped.
    always_comb begin
        w_pend_nxt = r_pend;
        w_under    = {NUM_ARCH_REGS{1'b0}};
        w_up       = {SUM_W{1'b0}};
        w_down     = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            w_up = SUM_W'(r_pend[i]);
            if (inc_en_i && (inc_addr_i == reg_addr_t'(i)) && (reg_addr_t'(i) != REG_ZERO)) begin
                w_up = w_up + SUM_W'(1);
            end else begin
                w_up = w_up;
            end
            w_down = {SUM_W{1'b0}};
            for (int j = 0; j < W_PORTS; j++) begin
                if (dec_en_i[j] && (dec_addr_i[ADDR_W*j +: ADDR_W] == reg_addr_t'(i)) &&
                    (reg_addr_t'(i) != REG_ZERO)) begin
                    w_down = w_down + SUM_W'(1);
                end else begin
                    w_down = w_down;
                end
            end
            if (w_down > w_up) begin
                w_pend_nxt[i] = {PEND_W{1'b0}};
                w_under[i]    = 1'b1;
            end else if ((w_up - w_down) > SUM_W'(PEND_MAX)) begin
                w_pend_nxt[i] = PEND_MAX;
            end else begin
                w_pend_nxt[i] = PEND_W'(w_up - w_down);
            end
        end
    end

    // Counter and sticky underflow flag state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= {(NUM_ARCH_REGS*PEND_W){1'b0}};
            r_err  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_err  <= r_err | (|w_under);
        end
    end

    // Saturation view used to hold back issue of another writer.
    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            sat_o[i] = (r_pend[i] == PEND_MAX);
        end
    end

    assign pend_o = r_pend;
    assign err_o  = r_err;

endmodule

// File: rtl/core_opnd_fetch.sv
// Operand-fetch stage: holds one decoded instruction, reads the register
// file, waits on pending writes, forwards same-cycle writeback data and
// hands the resolved operands downstream.
module core_opnd_fetch
    import core_pkg::*;
#(
    parameter int W_PORTS = 2,
    parameter int PEND_W  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [15:0]                 in_op_i,
    input  logic [3:0]                  in_rs_i,
    input  logic [3:0]                  in_rt_i,
    input  logic                        in_use_rs_i,
    input  logic                        in_use_rt_i,
    input  logic [3:0]                  in_rd_i,
    input  logic                        in_rd_we_i,
    output logic [3:0]                  arf_ra_addr_o,
    output logic [3:0]                  arf_rb_addr_o,
    input  logic [15:0]                 arf_ra_data_i,
    input  logic [15:0]                 arf_rb_data_i,
    input  logic [W_PORTS-1:0]          wb_en_i,
    input  logic [4*W_PORTS-1:0]        wb_addr_i,
    input  logic [16*W_PORTS-1:0]       wb_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [15:0]                 out_op_o,
    output logic [15:0]                 out_a_o,
    output logic [15:0]                 out_b_o,
    output logic [3:0]                  out_rd_o,
    output logic                        out_rd_we_o,
    input  logic                        flush_i,
    output logic                        sb_err_o
);

    opf_state_e r_state;
    word_t      r_op;
    reg_addr_t  r_rs;
    reg_addr_t  r_rt;
    reg_addr_t  r_rd;
    logic       r_rd_we;
    logic       r_a_cap;
    logic       r_b_cap;
    word_t      r_a;
    word_t      r_b;

    logic [NUM_ARCH_REGS-1:0][PEND_W-1:0] w_pend;
    logic [NUM_ARCH_REGS-1:0]             w_sat;
    logic                                 w_err;
    logic                                 w_out_valid;
    logic                                 w_fire;
    logic                                 w_in_ready;
    logic                                 w_accept;
    logic [WORD_W:0]                      w_res_a;
    logic [WORD_W:0]                      w_res_b;
    logic                                 w_a_take;
    logic                                 w_b_take;

    // {resolved, value}: ARF when nothing is in flight; bypass only when the
    // single outstanding write retires this cycle (highest port wins).
    function automatic logic [WORD_W:0] resolve_opnd(
        input reg_addr_t                    addr,
        input logic [PEND_W-1:0]            pend,
        input word_t                        arf_data,
        input logic [W_PORTS-1:0]           en,
        input logic [ADDR_W*W_PORTS-1:0]    wa,
        input logic [WORD_W*W_PORTS-1:0]    wd
    );
        logic [WORD_W:0] res;
        res = {1'b0, {WORD_W{1'b0}}};
        if (pend == {PEND_W{1'b0}}) begin
            res = {1'b1, arf_data};
        end else if (pend == PEND_W'(1)) begin
            for (int j = 0; j < W_PORTS; j++) begin
                if (en[j] && (wa[ADDR_W*j +: ADDR_W] == addr)) begin
                    res = {1'b1, wd[WORD_W*j +: WORD_W]};
                end else begin
                    res = res;
                end
            end
        end else begin
            res = {1'b0, {WORD_W{1'b0}}};
        end
        return res;
    endfunction

    // Handshake and operand resolution for the held instruction.
    always_comb begin
        w_out_valid = (r_state == OPF_READY) &&
                      (!r_rd_we || (r_rd == REG_ZERO) || !w_sat[r_rd]);
        w_fire      = w_out_valid && out_ready_i;
        w_in_ready  = (r_state == OPF_EMPTY) || ((r_state == OPF_READY) && w_fire);
        w_accept    = in_valid_i && w_in_ready;
        w_res_a     = resolve_opnd(r_rs, w_pend[r_rs], arf_ra_data_i, wb_en_i, wb_addr_i, wb_data_i);
        w_res_b     = resolve_opnd(r_rt, w_pend[r_rt], arf_rb_data_i, wb_en_i, wb_addr_i, wb_data_i);
        w_a_take    = !r_a_cap && w_res_a[WORD_W];
        w_b_take    = !r_b_cap && w_res_b[WORD_W];
    end

    core_scoreboard #(
        .W_PORTS (W_PORTS),
        .PEND_W  (PEND_W)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_en_i   (w_fire && r_rd_we && (r_rd != REG_ZERO)),
        .inc_addr_i (r_rd),
        .dec_en_i   (wb_en_i),
        .dec_addr_i (wb_addr_i),
        .pend_o     (w_pend),
        .sat_o      (w_sat),
        .err_o      (w_err)
    );

    // Stage FSM: flush beats accept, accept beats plain fire, WAIT captures.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= OPF_EMPTY;
            r_op    <= 16'h0000;
            r_rs    <= 4'd0;
            r_rt    <= 4'd0;
            r_rd    <= 4'd0;
            r_rd_we <= 1'b0;
            r_a_cap <= 1'b0;
            r_b_cap <= 1'b0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
        end else if (flush_i) begin
            r_state <= OPF_EMPTY;
            r_a_cap <= 1'b0;
            r_b_cap <= 1'b0;
        end else if (w_accept) begin
            r_state <= OPF_WAIT;
            r_op    <= in_op_i;
            r_rs    <= in_rs_i;
            r_rt    <= in_rt_i;
            r_rd    <= in_rd_i;
            r_rd_we <= in_rd_we_i;
            r_a_cap <= !in_use_rs_i || (in_rs_i == REG_ZERO);
            r_b_cap <= !in_use_rt_i || (in_rt_i == REG_ZERO);
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
        end else if (w_fire) begin
            r_state <= OPF_EMPTY;
        end else if (r_state == OPF_WAIT) begin
            if (w_a_take) begin
                r_a     <= w_res_a[WORD_W-1:0];
                r_a_cap <= 1'b1;
            end
            if (w_b_take) begin
                r_b     <= w_res_b[WORD_W-1:0];
                r_b_cap <= 1'b1;
            end
            if ((r_a_cap || w_a_take) && (r_b_cap || w_b_take)) begin
                r_state <= OPF_READY;
            end
        end
    end

    assign in_ready_o    = w_in_ready;
    assign out_valid_o   = w_out_valid;
    assign out_op_o      = r_op;
    assign out_a_o       = r_a;
    assign out_b_o       = r_b;
    assign out_rd_o      = r_rd;
    assign out_rd_we_o   = r_rd_we;
    assign arf_ra_addr_o = r_rs;
    assign arf_rb_addr_o = r_rt;
    assign sb_err_o      = w_err;

endmodule

// File: tb/tb_core_opnd_fetch.sv
// Directed bench for core_opnd_fetch: a vector table of hazard-free
// instructions plus hand-written multi-cycle hazard/flush sequences.
module tb_core_opnd_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_op;
    logic [3:0]  in_rs, in_rt, in_rd;
    logic        in_use_rs, in_use_rt, in_rd_we;
    logic [3:0]  arf_ra_addr, arf_rb_addr;
    logic [15:0] arf_ra_data, arf_rb_data;
    logic [1:0]  wb_en;
    logic [7:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [15:0] out_op, out_a, out_b;
    logic [3:0]  out_rd;
    logic        out_rd_we, flush, sb_err;

    logic [15:0] arf_mem [16];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] op;
        logic [3:0]  rs, rt;
        logic        urs, urt;
        logic [3:0]  rd;
        logic        we;
        logic [15:0] ea, eb;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    assign arf_ra_data = arf_mem[arf_ra_addr];
    assign arf_rb_data = arf_mem[arf_rb_addr];

    core_opnd_fetch #(.W_PORTS(2), .PEND_W(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
        .in_rs_i(in_rs), .in_rt_i(in_rt), .in_use_rs_i(in_use_rs), .in_use_rt_i(in_use_rt),
        .in_rd_i(in_rd), .in_rd_we_i(in_rd_we),
        .arf_ra_addr_o(arf_ra_addr), .arf_rb_addr_o(arf_rb_addr),
        .arf_ra_data_i(arf_ra_data), .arf_rb_data_i(arf_rb_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_op_o(out_op),
        .out_a_o(out_a), .out_b_o(out_b), .out_rd_o(out_rd), .out_rd_we_o(out_rd_we),
        .flush_i(flush), .sb_err_o(sb_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: from a falling edge through the rising edge to the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic urs, input logic urt, input logic [3:0] rd, input logic we);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt;
        in_use_rs = urs; in_use_rt = urt; in_rd = rd; in_rd_we = we;
        step();
        in_valid = 1'b0;
    endtask

    // Issue an operand-free instruction and let it fire (accept, capture, fire).
    task automatic run_one(input logic [15:0] op, input logic [3:0] rd);
        issue(op, 4'd0, 4'd0, 1'b0, 1'b0, rd, 1'b1);
        step();
        step();
    endtask

    task automatic wb(input logic [1:0] en, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1);
        wb_en = en; wb_addr = {a1, a0}; wb_data = {d1, d0};
        step();
        wb_en = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) arf_mem[i] = 16'h0000;
        arf_mem[0] = 16'hDEAD; arf_mem[1] = 16'h0005; arf_mem[2] = 16'h0007;
        arf_mem[4] = 16'h4444; arf_mem[8] = 16'h1234; arf_mem[9] = 16'hABCD;
        arf_mem[10] = 16'h8000; arf_mem[15] = 16'hFFFF;

        vecs[0] = '{16'h1111, 4'd1,  4'd2,  1'b1, 1'b1, 4'd0,  1'b1, 16'h0005, 16'h0007};
        vecs[1] = '{16'h2222, 4'd8,  4'd9,  1'b1, 1'b0, 4'd12, 1'b0, 16'h1234, 16'h0000};
        vecs[2] = '{16'h3333, 4'd0,  4'd15, 1'b1, 1'b1, 4'd0,  1'b0, 16'h0000, 16'hFFFF};
        vecs[3] = '{16'h4444, 4'd10, 4'd10, 1'b0, 1'b1, 4'd1,  1'b0, 16'h0000, 16'h8000};
        vecs[4] = '{16'h5555, 4'd15, 4'd0,  1'b1, 1'b1, 4'd7,  1'b0, 16'hFFFF, 16'h0000};
        vecs[5] = '{16'h6666, 4'd9,  4'd8,  1'b0, 1'b0, 4'd2,  1'b0, 16'h0000, 16'h0000};

        rst = 1'b1; in_valid = 1'b0; in_op = 16'h0000; in_rs = 4'd0; in_rt = 4'd0;
        in_use_rs = 1'b0; in_use_rt = 1'b0; in_rd = 4'd0; in_rd_we = 1'b0;
        wb_en = 2'b00; wb_addr = 8'h00; wb_data = 32'h0; out_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        repeat (3) step();

        // Reset state
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst sb_err", sb_err, 0);
        chk("rst out_a", out_a, 0);
        chk("rst out_b", out_b, 0);
        chk("rst out_op", out_op, 0);
        chk("rst out_rd/we", {out_rd, out_rd_we}, 0);
        chk("rst arf addrs", {arf_ra_addr, arf_rb_addr}, 0);
        rst = 1'b0;
        step();

        // add R3 = R1 + R2, then stall downstream one cycle
        issue(16'hA123, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1);
        chk("s1 valid after accept", out_valid, 0);
        chk("s1 arf addrs", {arf_ra_addr, arf_rb_addr}, {4'd1, 4'd2});
        out_ready = 1'b0;
        step();
        chk("s1 valid", out_valid, 1);
        chk("s1 a", out_a, 16'h0005);
        chk("s1 b", out_b, 16'h0007);
        chk("s1 op", out_op, 16'hA123);
        chk("s1 rd/we", {out_rd, out_rd_we}, {4'd3, 1'b1});
        chk("s1 in_ready stalled", in_ready, 0);
        step();
        chk("s1 hold valid", out_valid, 1);
        chk("s1 hold a", out_a, 16'h0005);
        out_ready = 1'b1;
        #1;
        chk("s1 in_ready on fire", in_ready, 1);
        step();
        chk("s1 valid after fire", out_valid, 0);
        chk("s1 pend3", dut.w_pend[3], 1);
        wb(2'b01, 4'd3, 4'd0, 16'h0033, 16'h0000);
        chk("s1 pend3 retired", dut.w_pend[3], 0);

        // Hazard-free vector table
        for (int k = 0; k < 6; k++) begin
            issue(vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].urs, vecs[k].urt, vecs[k].rd, vecs[k].we);
            chk($sformatf("v%0d lat", k), out_valid, 0);
            step();
            chk($sformatf("v%0d valid", k), out_valid, 1);
            chk($sformatf("v%0d a", k), out_a, vecs[k].ea);
            chk($sformatf("v%0d b", k), out_b, vecs[k].eb);
            chk($sformatf("v%0d op", k), out_op, vecs[k].op);
            chk($sformatf("v%0d rd/we", k), {out_rd, out_rd_we}, {vecs[k].rd, vecs[k].we});
            step();
            chk($sformatf("v%0d fired", k), out_valid, 0);
        end
        chk("tbl pend0", dut.w_pend[0], 0);

        // Back-to-back dependency on R4 resolved by the port-1 bypass
        issue(16'h0B01, 4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b1);
        step();
        chk("s2 I1 valid", out_valid, 1);
        in_valid = 1'b1; in_op = 16'h0B02; in_rs = 4'd1; in_rt = 4'd4;
        in_use_rs = 1'b1; in_use_rt = 1'b1; in_rd = 4'd0; in_rd_we = 1'b0;
        #1;
        chk("s2 b2b in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("s2 pend4", dut.w_pend[4], 1);
        chk("s2 wait0", out_valid, 0);
        step();
        chk("s2 wait1", out_valid, 0);
        step();
        chk("s2 wait2", out_valid, 0);
        wb(2'b10, 4'd0, 4'd4, 16'h0000, 16'hBEEF);
        chk("s2 valid", out_valid, 1);
        chk("s2 a", out_a, 16'h0005);
        chk("s2 b bypass", out_b, 16'hBEEF);
        chk("s2 op", out_op, 16'h0B02);
        chk("s2 pend4 retired", dut.w_pend[4], 0);
        step();

        // Two ports retire two writes to R5 in one cycle
        run_one(16'h0C01, 4'd5);
        run_one(16'h0C02, 4'd5);
        chk("s3 pend5=2", dut.w_pend[5], 2);
        wb(2'b11, 4'd5, 4'd5, 16'h1111, 16'h2222);
        chk("s3 pend5=0", dut.w_pend[5], 0);
        chk("s3 sb_err", sb_err, 0);

        // Saturated counter blocks a 4th writer of R6
        run_one(16'h0D01, 4'd6);
        run_one(16'h0D02, 4'd6);
        run_one(16'h0D03, 4'd6);
        chk("s4 pend6=3", dut.w_pend[6], 3);
        issue(16'h0D04, 4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1);
        step();
        chk("s4 blocked", out_valid, 0);
        chk("s4 in_ready blocked", in_ready, 0);
        step();
        chk("s4 still blocked", out_valid, 0);
        wb(2'b01, 4'd6, 4'd0, 16'h0006, 16'h0000);
        chk("s4 unblocked", out_valid, 1);
        chk("s4 op", out_op, 16'h0D04);
        step();
        chk("s4 pend6 after fire", dut.w_pend[6], 3);
        wb(2'b11, 4'd6, 4'd6, 16'h0006, 16'h0006);
        wb(2'b01, 4'd6, 4'd0, 16'h0006, 16'h0000);
        chk("s4 pend6 drained", dut.w_pend[6], 0);
        chk("s4 sb_err", sb_err, 0);

        // Writeback to R0 is ignored
        wb(2'b01, 4'd0, 4'd0, 16'hFFFF, 16'h0000);
        chk("s5 sb_err R0 wb", sb_err, 0);
        chk("s5 pend0", dut.w_pend[0], 0);

        // Flush in WAIT, flush beating an accept, then underflow on R7
        run_one(16'h0E01, 4'd13);
        issue(16'h0E02, 4'd13, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        step();
        chk("s6 waiting", out_valid, 0);
        chk("s6 in_ready in WAIT", in_ready, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s6 flushed in_ready", in_ready, 1);
        chk("s6 flushed valid", out_valid, 0);
        in_valid = 1'b1; in_op = 16'h0E03; in_use_rs = 1'b0; in_use_rt = 1'b0;
        in_rd = 4'd0; in_rd_we = 1'b0; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        step();
        chk("s6 flush beats accept", out_valid, 0);
        chk("s6 pend13 kept", dut.w_pend[13], 1);
        wb(2'b01, 4'd7, 4'd0, 16'h0777, 16'h0000);
        chk("s6 sb_err set", sb_err, 1);
        chk("s6 pend7", dut.w_pend[7], 0);
        wb(2'b01, 4'd13, 4'd0, 16'h0D0D, 16'h0000);
        chk("s6 pend13 retired", dut.w_pend[13], 0);
        chk("s6 sb_err sticky", sb_err, 1);

        // Both ports hit the awaited register: highest port supplies the data
        run_one(16'h0F01, 4'd11);
        issue(16'h0F02, 4'd11, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        wb(2'b11, 4'd11, 4'd11, 16'h1111, 16'h2222);
        chk("s7 valid", out_valid, 1);
        chk("s7 a port1", out_a, 16'h2222);
        step();
        chk("s7 pend11", dut.w_pend[11], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/core_opnd_fetch.md
# core_opnd_fetch

Operand-fetch stage that sits on the read side of the 16 x 16-bit architectural register file. It accepts one decoded instruction at a time, drives the two register-file read ports, and tracks in-flight writes with a per-register pending scoreboard. It stalls on read-after-write hazards, forwards same-cycle writeback data, and hands resolved operands downstream with a valid/ready handshake.

## Interface
Parameters:
- W_PORTS, 2: number of writeback ports snooped; these are the same ports that write the register file.
- PEND_W, 2: width of each per-register pending-write counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  decoded instruction valid.
- in_ready_o  out  1  stage can accept an instruction.
- in_op_i  in  16  raw instruction word, passed through.
- in_rs_i, in_rt_i  in  4 each  source register addresses.
- in_use_rs_i, in_use_rt_i  in  1 each  source is actually read.
- in_rd_i  in  4  destination register.
- in_rd_we_i  in  1  instruction writes in_rd_i.
- arf_ra_addr_o, arf_rb_addr_o  out  4 each  register-file read addresses.
- arf_ra_data_i, arf_rb_data_i  in  16 each  combinational read data.
- wb_en_i  in  W_PORTS  writeback enables.
- wb_addr_i  in  4*W_PORTS  writeback addresses; port j is at bits [4j+3:4j].
- wb_data_i  in  16*W_PORTS  writeback data.
- out_valid_o  out  1  operands resolved.
- out_ready_i  in  1  downstream accepts.
- out_op_o  out  16  instruction word.
- out_a_o, out_b_o  out  16 each  operand values (rs, rt).
- out_rd_o  out  4  destination register.
- out_rd_we_o  out  1  destination write enable.
- flush_i  in  1  discard the held instruction.
- sb_err_o  out  1  sticky scoreboard underflow flag.

## Operation
- States:
  - EMPTY: no instruction held.
  - WAIT: instruction held, one or more operands unresolved.
  - READY: both operands captured.
- in_ready_o = (state==EMPTY) | (state==READY & out_valid_o & out_ready_i).
- Accept (in_valid_i & in_ready_o):
  - Latches op, rs, rt, rd, rd_we and the use flags.
  - Each operand with use=0, or with address 0, is marked captured with value 0.
  - Next state is WAIT.
- Operand A in WAIT: arf_ra_addr_o = held rs. Operand B uses arf_rb_addr_o = held rt, with the same rules. Each cycle, every uncaptured operand with register r resolves as follows:
  - pend[r]==0: capture the arf data.
  - pend[r]==1 and some wb_en_i[j] with wb_addr_i[j]==r: capture wb_data_i[j]. The highest j wins if several ports match.
  - Otherwise: keep waiting.
- WAIT→READY at the edge where both operands are captured (already, or this cycle).
- out_valid_o = (state==READY) & (rd_we==0 | rd==0 | pend[rd] != max). A saturated counter therefore blocks issue.
- Output fire (out_valid_o & out_ready_i):
  - If rd_we & rd!=0, pend[rd] increments.
  - Next state is the newly accepted instruction (WAIT) if one is accepted in the same cycle, else EMPTY.
- Writeback: each wb_en_i[j] with address !=0 decrements pend[addr].
  - Multiple ports to the same register decrement by the match count.
  - An increment and decrements in the same cycle apply as a net change.
  - A decrement below 0 clamps the counter at 0 and sets sb_err_o.
- Register 0 is never marked pending and always reads as 0.
- flush_i: state→EMPTY next edge; captures discarded. The scoreboard is not touched, since in-flight writes still retire. flush_i overrides an accept in the same cycle. A fire in the flush cycle still counts; downstream has already taken it.

## Timing
- Reset values:
  - state EMPTY, all pend 0.
  - out_valid_o 0, sb_err_o 0, in_ready_o 1.
  - out_a_o, out_b_o, out_op_o, out_rd_o 0; out_rd_we_o 0.
  - arf_ra_addr_o, arf_rb_addr_o 0.
- Minimum latency: accept at edge E0, capture at E1, out_valid_o high in the cycle after E1. Back-to-back throughput is one instruction every 2 cycles without hazards.
- Outputs are registered, except in_ready_o and out_valid_o, which are combinational from state, pend and out_ready_i.
- Once out_valid_o is high, outputs hold stable until fire or flush.
- Back-to-back dependency: an instruction issued at edge E marks pend[rd] at E. A dependent instruction in WAIT observes pend[rd]==1 in the following cycle.

## Structure
- Shared core_pkg holds:
  - reg_addr_t (logic [3:0]) and word_t (logic [15:0]).
  - NUM_ARCH_REGS = 16, REG_ZERO = 0.
- One sub-module: core_scoreboard, holding the 16 PEND_W-bit counters.
  - Inputs: issue inc port, W_PORTS dec ports.
  - Outputs: per-register pend values, a saturation vector, and the underflow flag.

## Test plan
- Reset, then insert add R3=R1+R2 with no pending writes and ARF R1=0x0005, R2=0x0007 -> out_valid_o 2 cycles after accept; a=0x0005, b=0x0007; pend[3]=1 after fire.
- Issue writes R4; next instruction reads R4; wb port 1 writes R4=0xBEEF 3 cycles later -> held in WAIT until then; b=0xBEEF captured from the bypass; pend[4] returns to 0.
- Two wb ports write R5 in the same cycle, pend[5]=2, with data 0x1111 (port 0) and 0x2222 (port 1) -> pend[5]=0; sb_err_o stays 0.
- With PEND_W=2, issue 3 writes to R6 with no wb, then a 4th instruction writing R6 -> out_valid_o low until a wb to R6 arrives.
- Source rs=R0 with use=1 -> a=0 regardless of ARF content; wb to R0 leaves sb_err_o at 0.
- flush_i in WAIT, then a wb to an unmarked register R7 -> state EMPTY; sb_err_o=1 and pend[7] stays 0.
